rps_round_referee: RTL and testbench

//   Consumer end of the 2-bit player choice code (00=Unset, 01=Rock, 10=Paper, 11=Scissors).

---
 rtl/rps_round_referee.sv | 241 ++++++++++++++++++++++++
 tb/tb_rps_round_referee.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_round_referee.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rps_round_referee                                                         |
// | Judges rock-paper-scissors rounds once both encoded choices are stable,   |
// | keeps per-player scores and declares the match winner at WIN_SCORE.       |
// | Optional feature macro: RPS_TIE_COUNT_EN (adds saturating tie_count).     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rps_round_referee #(
  parameter int STABLE_CYCLES = 4,
  parameter int SHOW_CYCLES   = 8,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         p1_choice,
  input  logic [1:0]         p2_choice,
  input  logic               round_clear,
  output logic [1:0]         winner,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic               busy
`ifdef RPS_TIE_COUNT_EN
  ,
  output logic [SCORE_W-1:0] tie_count
`endif
);

  localparam int c_settle_w = $clog2(STABLE_CYCLES + 1);
  localparam int c_show_w   = $clog2(SHOW_CYCLES + 1);

  localparam logic [c_settle_w-1:0] c_settle_max = c_settle_w'(STABLE_CYCLES);
  localparam logic [c_settle_w-1:0] c_settle_one = c_settle_w'(1);
  localparam logic [c_show_w-1:0]   c_show_max   = c_show_w'(SHOW_CYCLES);
  localparam logic [c_show_w-1:0]   c_show_one   = c_show_w'(1);
  localparam logic [SCORE_W-1:0]    c_win        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]    c_score_one  = SCORE_W'(1);

  typedef enum logic [2:0] {
    ST_WAIT_BOTH    = 3'd0,
    ST_SETTLE       = 3'd1,
    ST_SHOW         = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_MATCH_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_cap1;
  logic [1:0]            r_cap2;
  logic [1:0]            w_cap1_nxt;
  logic [1:0]            w_cap2_nxt;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_settle_w-1:0] w_settle_cnt_nxt;
  logic [c_show_w-1:0]   r_show_cnt;
  logic [c_show_w-1:0]   w_show_cnt_nxt;
  logic [1:0]            r_winner;
  logic [1:0]            w_winner_nxt;
  logic                  r_result_valid;
  logic                  w_result_valid_nxt;
  logic [SCORE_W-1:0]    r_p1_score;
  logic [SCORE_W-1:0]    w_p1_score_nxt;
  logic [SCORE_W-1:0]    r_p2_score;
  logic [SCORE_W-1:0]    w_p2_score_nxt;
  logic [1:0]            r_match_winner;
  logic [1:0]            w_match_winner_nxt;
  logic [1:0]            w_verdict;
  logic                  w_both_set;
  logic                  w_both_clear;
  logic                  w_changed;
`ifdef RPS_TIE_COUNT_EN
  localparam logic [SCORE_W-1:0] c_tie_max = {SCORE_W{1'b1}};
  logic [SCORE_W-1:0]    r_tie_count;
  logic [SCORE_W-1:0]    w_tie_count_nxt;
`endif

  // Verdict codes: 01 player 1, 10 player 2, 11 tie.
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] v;
    if (a == b) begin
      v = 2'b11;
    end else begin
      case ({a, b})
        4'b0111, 4'b1001, 4'b1110: v = 2'b01;
        default:                   v = 2'b10;
      endcase
    end
    return v;
  endfunction

  assign w_both_set   = (p1_choice != 2'b00) && (p2_choice != 2'b00);
  assign w_both_clear = (p1_choice == 2'b00) && (p2_choice == 2'b00);
  assign w_changed    = (p1_choice != r_cap1) || (p2_choice != r_cap2);
  assign w_verdict    = judge(r_cap1, r_cap2);

  always_comb begin
    w_state_nxt        = r_state;
    w_cap1_nxt         = r_cap1;
    w_cap2_nxt         = r_cap2;
    w_settle_cnt_nxt   = r_settle_cnt;
    w_show_cnt_nxt     = r_show_cnt;
    w_winner_nxt       = r_winner;
    w_result_valid_nxt = 1'b0;
    w_p1_score_nxt     = r_p1_score;
    w_p2_score_nxt     = r_p2_score;
    w_match_winner_nxt = r_match_winner;
`ifdef RPS_TIE_COUNT_EN
    w_tie_count_nxt    = r_tie_count;
`endif
    if (round_clear) begin
      w_state_nxt        = ST_WAIT_BOTH;
      w_settle_cnt_nxt   = '0;
      w_show_cnt_nxt     = '0;
      w_winner_nxt       = 2'b00;
      w_p1_score_nxt     = '0;
      w_p2_score_nxt     = '0;
      w_match_winner_nxt = 2'b00;
`ifdef RPS_TIE_COUNT_EN
      w_tie_count_nxt    = '0;
`endif
    end else begin
      case (r_state)
        ST_WAIT_BOTH: begin
          if (w_both_set) begin
            w_state_nxt      = ST_SETTLE;
            w_cap1_nxt       = p1_choice;
            w_cap2_nxt       = p2_choice;
            w_settle_cnt_nxt = c_settle_one;
          end
        end
        ST_SETTLE: begin
          if (!w_both_set) begin
            w_state_nxt      = ST_WAIT_BOTH;
            w_settle_cnt_nxt = '0;
          end else if (w_changed) begin
            w_cap1_nxt       = p1_choice;
            w_cap2_nxt       = p2_choice;
            w_settle_cnt_nxt = c_settle_one;
          end else if (r_settle_cnt == c_settle_max) begin
            // Captured values equal the live inputs here, so judge the capture.
            w_state_nxt        = ST_SHOW;
            w_settle_cnt_nxt   = '0;
            w_show_cnt_nxt     = c_show_one;
            w_winner_nxt       = w_verdict;
            w_result_valid_nxt = 1'b1;
            if (w_verdict == 2'b01) begin
              w_p1_score_nxt = r_p1_score + c_score_one;
            end else if (w_verdict == 2'b10) begin
              w_p2_score_nxt = r_p2_score + c_score_one;
            end
`ifdef RPS_TIE_COUNT_EN
            if ((w_verdict == 2'b11) && (r_tie_count != c_tie_max)) begin
              w_tie_count_nxt = r_tie_count + c_score_one;
            end
`endif
          end else begin
            w_settle_cnt_nxt = r_settle_cnt + c_settle_one;
          end
        end
        ST_SHOW: begin
          if (r_show_cnt == c_show_max) begin
            w_show_cnt_nxt = '0;
            w_winner_nxt   = 2'b00;
            if (r_p1_score == c_win) begin
              w_state_nxt        = ST_MATCH_DONE;
              w_match_winner_nxt = 2'b01;
            end else if (r_p2_score == c_win) begin
              w_state_nxt        = ST_MATCH_DONE;
              w_match_winner_nxt = 2'b10;
            end else begin
              w_state_nxt = ST_WAIT_RELEASE;
            end
          end else begin
            w_show_cnt_nxt = r_show_cnt + c_show_one;
          end
        end
        ST_WAIT_RELEASE: begin
          // Both players must let go before a held choice can be judged again.
          if (w_both_clear) begin
            w_state_nxt = ST_WAIT_BOTH;
          end
        end
        ST_MATCH_DONE: begin
          w_state_nxt = ST_MATCH_DONE;
        end
        default: begin
          w_state_nxt = ST_WAIT_BOTH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_WAIT_BOTH;
      r_cap1         <= 2'b00;
      r_cap2         <= 2'b00;
      r_settle_cnt   <= '0;
      r_show_cnt     <= '0;
      r_winner       <= 2'b00;
      r_result_valid <= 1'b0;
      r_p1_score     <= '0;
      r_p2_score     <= '0;
      r_match_winner <= 2'b00;
`ifdef RPS_TIE_COUNT_EN
      r_tie_count    <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_cap1         <= w_cap1_nxt;
      r_cap2         <= w_cap2_nxt;
      r_settle_cnt   <= w_settle_cnt_nxt;
      r_show_cnt     <= w_show_cnt_nxt;
      r_winner       <= w_winner_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_p1_score     <= w_p1_score_nxt;
      r_p2_score     <= w_p2_score_nxt;
      r_match_winner <= w_match_winner_nxt;
`ifdef RPS_TIE_COUNT_EN
      r_tie_count    <= w_tie_count_nxt;
`endif
    end
  end

  assign winner       = r_winner;
  assign result_valid = r_result_valid;
  assign p1_score     = r_p1_score;
  assign p2_score     = r_p2_score;
  assign match_over   = (r_state == ST_MATCH_DONE);
  assign match_winner = r_match_winner;
  assign busy         = (r_state != ST_WAIT_BOTH);
`ifdef RPS_TIE_COUNT_EN
  assign tie_count    = r_tie_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rps_round_referee.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rps_round_referee                                                      |
// | Directed and random stimulus against a behavioural round/match model.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_rps_round_referee;

  localparam int STABLE = 4;
  localparam int SHOW   = 8;
  localparam int WIN    = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] p1_choice;
  logic [1:0] p2_choice;
  logic       round_clear;
  logic [1:0] winner;
  logic       result_valid;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       match_over;
  logic [1:0] match_winner;
  logic       busy;
`ifdef RPS_TIE_COUNT_EN
  logic [3:0] tie_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rps_round_referee #(
    .STABLE_CYCLES(STABLE),
    .SHOW_CYCLES  (SHOW),
    .SCORE_W      (4),
    .WIN_SCORE    (WIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p1_choice    (p1_choice),
    .p2_choice    (p2_choice),
    .round_clear  (round_clear),
    .winner       (winner),
    .result_valid (result_valid),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .match_over   (match_over),
    .match_winner (match_winner),
    .busy         (busy)
`ifdef RPS_TIE_COUNT_EN
    ,
    .tie_count    (tie_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: run length of an identical nonzero pair, remaining
  // show time, and two flags for "needs release" and "match finished".
  int         m_run;
  int         m_show_left;
  bit         m_wrel;
  bit         m_done;
  logic [1:0] m_c1, m_c2;
  logic [1:0] e_winner, e_mw;
  logic       e_rv;
  int         e_s1, e_s2, e_tie;

  function automatic logic [1:0] ref_winner(input int a, input int b);
    if (a == b) return 2'b11;
    if (((a - b + 3) % 3) == 1) return 2'b01;
    return 2'b10;
  endfunction

  task automatic model_reset();
    m_run = 0; m_show_left = 0; m_wrel = 0; m_done = 0;
    m_c1 = 0; m_c2 = 0;
    e_winner = 0; e_mw = 0; e_rv = 0; e_s1 = 0; e_s2 = 0; e_tie = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || round_clear) begin
      model_reset();
    end else begin
      e_rv = 0;
      if (m_done) begin
      end else if (m_show_left > 0) begin
        m_show_left = m_show_left - 1;
        if (m_show_left == 0) begin
          e_winner = 0;
          if (e_s1 == WIN || e_s2 == WIN) begin
            m_done = 1;
            e_mw   = (e_s1 == WIN) ? 2'b01 : 2'b10;
          end else begin
            m_wrel = 1;
          end
        end
      end else if (m_wrel) begin
        if (p1_choice == 0 && p2_choice == 0) m_wrel = 0;
      end else if (m_run == 0) begin
        if (p1_choice != 0 && p2_choice != 0) begin
          m_c1 = p1_choice; m_c2 = p2_choice; m_run = 1;
        end
      end else if (p1_choice == 0 || p2_choice == 0) begin
        m_run = 0;
      end else if (p1_choice != m_c1 || p2_choice != m_c2) begin
        m_c1 = p1_choice; m_c2 = p2_choice; m_run = 1;
      end else if (m_run == STABLE) begin
        m_run       = 0;
        m_show_left = SHOW;
        e_rv        = 1;
        e_winner    = ref_winner(int'(m_c1), int'(m_c2));
        if (e_winner == 2'b01) e_s1 = e_s1 + 1;
        else if (e_winner == 2'b10) e_s2 = e_s2 + 1;
        else if (e_tie < 15) e_tie = e_tie + 1;
      end else begin
        m_run = m_run + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("winner", 32'(winner), 32'(e_winner));
    chk("result_valid", 32'(result_valid), 32'(e_rv));
    chk("p1_score", 32'(p1_score), 32'(e_s1));
    chk("p2_score", 32'(p2_score), 32'(e_s2));
    chk("match_over", 32'(match_over), 32'(m_done));
    chk("match_winner", 32'(match_winner), 32'(e_mw));
    chk("busy", 32'(busy),
        32'((m_run > 0) || (m_show_left > 0) || m_wrel || m_done));
`ifdef RPS_TIE_COUNT_EN
    chk("tie_count", 32'(tie_count), 32'(e_tie));
`endif
  endtask

  // Outputs only move on posedge or reset, so the falling edge is a safe sample point.
  task automatic tick();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b);
    p1_choice = a;
    p2_choice = b;
  endtask

  initial begin
    int cnt;
    int r;
    rst_n = 1'b0; round_clear = 1'b0; drive(2'd0, 2'd0);
    repeat (3) tick();
    chk("reset_winner", 32'(winner), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_scores", 32'({p1_score, p2_score}), 0);
    rst_n = 1'b1;
    tick();

    // Rock vs scissors: result 5 cycles after both set.
    drive(2'd1, 2'd3);
    repeat (4) tick();
    chk("t1_not_yet", 32'(result_valid), 0);
    tick();
    chk("t1_valid", 32'(result_valid), 1);
    chk("t1_winner", 32'(winner), 1);
    chk("t1_p1", 32'(p1_score), 1);
    chk("t1_p2", 32'(p2_score), 0);

    // Held choice must not re-judge.
    cnt = 0;
    repeat (30) begin tick(); cnt += int'(result_valid); end
    chk("t4_no_rejudge", 32'(cnt), 0);
    chk("t4_release_wait", 32'(busy), 1);
    drive(2'd0, 2'd0);
    tick();
    chk("t4_released", 32'(busy), 0);

    // Tie.
    drive(2'd2, 2'd2);
    repeat (5) tick();
    chk("t2_winner", 32'(winner), 3);
    chk("t2_valid", 32'(result_valid), 1);
    chk("t2_p1", 32'(p1_score), 1);
    chk("t2_p2", 32'(p2_score), 0);
`ifdef RPS_TIE_COUNT_EN
    chk("t2_tie", 32'(tie_count), 1);
`endif
    drive(2'd0, 2'd0);
    repeat (10) tick();
    chk("t2_idle", 32'(busy), 0);

    // Settle restart on a change.
    drive(2'd1, 2'd1);
    repeat (2) tick();
    drive(2'd1, 2'd3);
    repeat (4) tick();
    chk("t3_not_yet", 32'(result_valid), 0);
    tick();
    chk("t3_valid", 32'(result_valid), 1);
    chk("t3_p1", 32'(p1_score), 2);
    drive(2'd0, 2'd0);
    repeat (10) tick();

    // Dropping to unset during settle aborts the round.
    drive(2'd2, 2'd1);
    repeat (2) tick();
    drive(2'd2, 2'd0);
    tick();
    chk("t3_abort_idle", 32'(busy), 0);
    cnt = 0;
    repeat (6) begin tick(); cnt += int'(result_valid); end
    chk("t3_abort_nores", 32'(cnt), 0);
    chk("t3_abort_p1", 32'(p1_score), 2);

    // Player 2 takes the match with rock vs scissors.
    round_clear = 1'b1; tick(); round_clear = 1'b0;
    chk("t5_cleared", 32'(p1_score), 0);
    for (int k = 0; k < 3; k++) begin
      drive(2'd3, 2'd1);
      repeat (5) tick();
      chk("t5_valid", 32'(result_valid), 1);
      chk("t5_winner", 32'(winner), 2);
      chk("t5_p2", 32'(p2_score), 32'(k + 1));
      drive(2'd0, 2'd0);
      repeat (10) tick();
    end
    chk("t5_match_over", 32'(match_over), 1);
    chk("t5_match_winner", 32'(match_winner), 2);
    drive(2'd1, 2'd3);
    cnt = 0;
    repeat (12) begin tick(); cnt += int'(result_valid); end
    chk("t5_ignored", 32'(cnt), 0);
    chk("t5_p1_frozen", 32'(p1_score), 0);
    round_clear = 1'b1; tick(); round_clear = 1'b0;
    chk("t5_clear_over", 32'(match_over), 0);
    chk("t5_clear_mw", 32'(match_winner), 0);
    chk("t5_clear_p2", 32'(p2_score), 0);
    drive(2'd0, 2'd0);
    tick();

    // round_clear lands on the judge edge.
    drive(2'd1, 2'd3);
    repeat (4) tick();
    round_clear = 1'b1;
    tick();
    round_clear = 1'b0;
    chk("t6_no_valid", 32'(result_valid), 0);
    chk("t6_p1", 32'(p1_score), 0);
    chk("t6_idle", 32'(busy), 0);
    drive(2'd0, 2'd0);
    tick();

    // Asynchronous reset in the middle of SHOW.
    drive(2'd2, 2'd1);
    repeat (5) tick();
    chk("t6_show_winner", 32'(winner), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_winner", 32'(winner), 0);
    chk("t6_rst_p1", 32'(p1_score), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    drive(2'd0, 2'd0);
    tick();

    // Random phase: long holds so rounds and matches complete.
    for (int i = 0; i < 4000; i++) begin
      round_clear = 1'b0;
      rst_n = 1'b1;
      r = int'($urandom_range(0, 199));
      if (r < 150) begin
      end else if (r < 170) begin
        drive(2'd0, 2'd0);
      end else if (r < 176) begin
        if (r[0]) drive(2'd0, 2'($urandom_range(1, 3)));
        else      drive(2'($urandom_range(1, 3)), 2'd0);
      end else if (r < 197) begin
        drive(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)));
      end else if (r < 199) begin
        round_clear = 1'b1;
      end else begin
        rst_n = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
